// File: rtl/cic_decimator_if.sv
`default_nettype none
// ============================================================================
// Module      : cic_decimator_if
// Description : Sample-in / decimated-result-out bundle for cic_decimator.
// Revision    : 1.0 - initial release
// ============================================================================
interface cic_decimator_if #(
  parameter int IN_WIDTH  = 2,
  parameter int ACC_WIDTH = 14
);
  logic                        i_clr;
  logic                        i_sample;
  logic signed [IN_WIDTH-1:0]  i_data;
  logic signed [ACC_WIDTH-1:0] o_data;
  logic                        o_valid;
  logic                        o_busy;

  modport master (
    output i_clr, i_sample, i_data,
    input  o_data, o_valid, o_busy
  );

  modport slave (
    input  i_clr, i_sample, i_data,
    output o_data, o_valid, o_busy
  );
endinterface
`default_nettype wire

// File: rtl/cic_decimator.sv
`default_nettype none
// ============================================================================
// Module      : cic_decimator
// Description : Sinc^ORDER CIC decimator, ratio 2^DECIM_LOG2; combs run
//               sequentially at the decimated rate. DSM_CIC_WARMUP_EN drops
//               the first ORDER start-up results after reset/clear.
// Revision    : 1.0 - initial release
// ============================================================================
module cic_decimator #(
  parameter int IN_WIDTH   = 2,
  parameter int ORDER      = 3,
  parameter int DECIM_LOG2 = 4,
  parameter int ACC_WIDTH  = IN_WIDTH + ORDER * DECIM_LOG2
) (
  input  wire logic        i_clk,
  input  wire logic        i_rst_n,
  cic_decimator_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_COMB = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  localparam logic [1:0] c_last_stage = 2'(ORDER - 1);

  state_t                      r_state;
  state_t                      w_next;
  logic signed [ACC_WIDTH-1:0] r_integ [ORDER];
  logic signed [ACC_WIDTH-1:0] r_dly   [ORDER];
  logic signed [ACC_WIDTH-1:0] r_snap;
  logic signed [ACC_WIDTH-1:0] r_work;
  logic signed [ACC_WIDTH-1:0] r_data;
  logic                        r_valid;
  logic [DECIM_LOG2-1:0]       r_cnt;
  logic [1:0]                  r_k;

  logic signed [ACC_WIDTH-1:0] w_ext;
  logic signed [ACC_WIDTH-1:0] w_cur;
  logic                        w_event;
  logic                        w_emit;
  logic                        w_emit_ok;

  assign w_ext   = {{(ACC_WIDTH-IN_WIDTH){bus.i_data[IN_WIDTH-1]}}, bus.i_data};
  assign w_event = bus.i_sample && (r_cnt == '1);
  // The first comb stage consumes the snapshot, later stages the running value.
  assign w_cur   = (r_k == 2'd0) ? r_snap : r_work;

`ifdef DSM_CIC_WARMUP_EN
  logic [2:0] r_warm;

  assign w_emit_ok = (r_warm >= 3'(ORDER));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_warm <= 3'd0;
    end else if (bus.i_clr) begin
      r_warm <= 3'd0;
    end else if (r_state == S_OUT && !w_emit_ok) begin
      r_warm <= r_warm + 3'd1;
    end
  end
`else
  assign w_emit_ok = 1'b1;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else if (bus.i_clr) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_emit = 1'b0;
    case (r_state)
      S_IDLE: if (w_event) w_next = S_COMB;
      S_COMB: if (r_k == c_last_stage) w_next = S_OUT;
      S_OUT: begin
        w_emit = w_emit_ok;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < ORDER; k++) begin
        r_integ[k] <= '0;
        r_dly[k]   <= '0;
      end
      r_snap  <= '0;
      r_work  <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
      r_k     <= 2'd0;
    end else if (bus.i_clr) begin
      for (int k = 0; k < ORDER; k++) begin
        r_integ[k] <= '0;
        r_dly[k]   <= '0;
      end
      r_snap  <= '0;
      r_work  <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
      r_k     <= 2'd0;
    end else begin
      r_valid <= 1'b0;
      if (bus.i_sample) begin
        // Each stage adds the pre-edge value of its predecessor (pipelined chain).
        r_integ[0] <= r_integ[0] + w_ext;
        for (int k = 1; k < ORDER; k++) begin
          r_integ[k] <= r_integ[k] + r_integ[k-1];
        end
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_event) begin
        r_snap <= r_integ[ORDER-1];
        r_k    <= 2'd0;
      end
      if (r_state == S_COMB) begin
        r_work     <= w_cur - r_dly[r_k];
        r_dly[r_k] <= w_cur;
        r_k        <= r_k + 2'd1;
      end
      if (w_emit) begin
        r_data  <= r_work;
        r_valid <= 1'b1;
      end
    end
  end

  assign bus.o_data  = r_data;
  assign bus.o_valid = r_valid;
  assign bus.o_busy  = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_cic_decimator.sv
`default_nettype none
// ============================================================================
// Module      : tb_cic_decimator
// Description : Scoreboard bench for cic_decimator (ORDER=3, DECIM=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cic_decimator;

  localparam int IN_W  = 2;
  localparam int ORDER = 3;
  localparam int DL    = 4;
  localparam int DECIM = 1 << DL;
  localparam int ACC_W = IN_W + ORDER * DL;
`ifdef DSM_CIC_WARMUP_EN
  localparam int WARM = ORDER;
`else
  localparam int WARM = 0;
`endif

  typedef struct {
    longint val;
    int     cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  cic_decimator_if #(.IN_WIDTH(IN_W), .ACC_WIDTH(ACC_W)) bus ();

  cic_decimator #(
    .IN_WIDTH  (IN_W),
    .ORDER     (ORDER),
    .DECIM_LOG2(DL),
    .ACC_WIDTH (ACC_W)
  ) u_dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_errors = 0;
  int     cyc = 0;
  exp_t   q[$];
  longint mi[ORDER];
  longint md[ORDER];
  int     mcnt;
  int     mwarm;
  bit     dc_on;
  longint dc_exp;
  int     nres;
  bit     rec_on;
  bit     cmp_on;
  longint ref_seq[$];

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic longint wrap(input longint v);
    logic signed [ACC_W-1:0] t;
    t = v[ACC_W-1:0];
    return longint'(t);
  endfunction

  task automatic model_clear();
    for (int k = 0; k < ORDER; k++) begin
      mi[k] = 0;
      md[k] = 0;
    end
    mcnt  = 0;
    mwarm = 0;
    q.delete();
  endtask

  // Called at the negedge before the posedge that consumes d.
  task automatic model_sample(input int d);
    if (mcnt == DECIM - 1) begin
      longint c;
      exp_t   e;
      c = mi[ORDER-1];
      for (int k = 0; k < ORDER; k++) begin
        longint t;
        t     = c - md[k];
        md[k] = c;
        c     = t;
      end
      if (mwarm < WARM) begin
        mwarm++;
      end else begin
        e.val = wrap(c);
        e.cyc = cyc + 1 + ORDER + 1;
        q.push_back(e);
      end
    end
    for (int k = ORDER - 1; k > 0; k--) mi[k] = mi[k] + mi[k-1];
    mi[0] = mi[0] + longint'(d);
    mcnt  = (mcnt + 1) % DECIM;
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.o_valid) begin
      if (q.size() == 0) begin
        check("spurious_valid", longint'(bus.o_valid), 0);
      end else begin
        exp_t   e;
        longint got;
        e   = q.pop_front();
        got = longint'(bus.o_data);
        check("result_value", got, e.val);
        check("result_latency", cyc, e.cyc);
        nres++;
        if (dc_on && nres > ORDER - WARM) check("dc_gain", got, dc_exp);
        if (rec_on) ref_seq.push_back(got);
        if (cmp_on && nres <= ref_seq.size()) check("sparse_equal", got, ref_seq[nres-1]);
      end
    end
  end

  task automatic step(input bit en, input int d);
    @(negedge clk);
    bus.i_sample = en;
    bus.i_data   = (IN_W)'(d);
    if (en) model_sample(d);
  endtask

  task automatic do_clr();
    @(negedge clk);
    bus.i_clr    = 1'b1;
    bus.i_sample = 1'b0;
    model_clear();
    @(negedge clk);
    bus.i_clr = 1'b0;
    check("clr_data", longint'(bus.o_data), 0);
    check("clr_busy", longint'(bus.o_busy), 0);
  endtask

  task automatic drain();
    repeat (12) step(1'b0, 0);
    check("queue_drained", q.size(), 0);
  endtask

  task automatic run_dc(input int d, input int gap);
    nres   = 0;
    dc_on  = 1'b1;
    dc_exp = longint'(d) * DECIM * DECIM * DECIM;
    for (int n = 0; n < 128; n++) begin
      step(1'b1, d);
      repeat (gap) step(1'b0, 0);
    end
    step(1'b0, 0);
    drain();
    check("dc_result_count", nres, 8 - WARM);
    dc_on = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    bus.i_clr    = 1'b0;
    bus.i_sample = 1'b0;
    bus.i_data   = '0;
    dc_on = 0; rec_on = 0; cmp_on = 0; nres = 0;
    model_clear();
    repeat (4) @(negedge clk);
    check("reset_data", longint'(bus.o_data), 0);
    check("reset_valid", longint'(bus.o_valid), 0);
    check("reset_busy", longint'(bus.o_busy), 0);
    rst_n = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      check("idle_data", longint'(bus.o_data), 0);
      check("idle_valid", longint'(bus.o_valid), 0);
      check("idle_busy", longint'(bus.o_busy), 0);
    end

    // DC +1 dense, recorded as reference for the sparse run.
    rec_on = 1'b1;
    run_dc(1, 0);
    rec_on = 1'b0;

    do_clr();
    run_dc(-2, 0);

    do_clr();
    cmp_on = 1'b1;
    run_dc(1, 2);
    cmp_on = 1'b0;

    // Second dense +1 run after clear: warm-up must repeat.
    do_clr();
    run_dc(1, 0);

    // Clear one cycle after a decimation event aborts that frame.
    do_clr();
    for (int n = 0; n < DECIM; n++) step(1'b1, 1);
    @(negedge clk);
    check("busy_mid_comb", longint'(bus.o_busy), 1);
    bus.i_clr    = 1'b1;
    bus.i_sample = 1'b0;
    model_clear();
    @(negedge clk);
    bus.i_clr = 1'b0;
    check("abort_data", longint'(bus.o_data), 0);
    check("abort_busy", longint'(bus.o_busy), 0);
    repeat (10) step(1'b0, 0);
    nres = 0;
    for (int n = 0; n < 64; n++) step(1'b1, 0);
    drain();
    check("zero_result_count", nres, 4 - WARM);

    // Asynchronous reset while the comb FSM is running.
    do_clr();
    for (int n = 0; n < DECIM; n++) step(1'b1, 1);
    @(posedge clk);
    #1;
    check("busy_before_rst", longint'(bus.o_busy), 1);
    bus.i_sample = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("async_valid", longint'(bus.o_valid), 0);
    check("async_busy", longint'(bus.o_busy), 0);
    check("async_data", longint'(bus.o_data), 0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    run_dc(1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cic_decimator.md
Name: cic_decimator

Overview:
- Sinc^N (CIC) decimation filter at the receiving end of the delta-sigma path.
- Takes the multi-bit modulator stream at the oversampled rate, qualified by i_sample.
- Emits one filtered, decimated word every 2^DECIM_LOG2 accepted samples.
- Integrators run at the sample rate; comb stages are evaluated sequentially by a small FSM at the decimated rate.

Parameters:
- IN_WIDTH, 2: signed input word width.
- ORDER, 3: number of integrator and comb stages; legal range 1..4.
- DECIM_LOG2, 4: log2 of the decimation ratio, DECIM = 2^DECIM_LOG2; legal range 3..10.
- ACC_WIDTH, IN_WIDTH + ORDER*DECIM_LOG2: width of every integrator, comb and the output (Hogenauer bound).

Ports:
- i_clk  input  1  clock.
- i_rst_n  input  1  reset.
- i_clr  input  1  synchronous clear of all filter state; has priority over i_sample.
- i_sample  input  1  input qualifier; i_data is consumed on cycles where this is high.
- i_data  input  IN_WIDTH  signed modulator sample.
- o_data  output  ACC_WIDTH  signed decimated result; holds its value between updates.
- o_valid  output  1  single-cycle pulse when o_data has just been updated.
- o_busy  output  1  high while the comb FSM is not IDLE.

Behaviour:
- Reset and clock: reset i_rst_n, asynchronous, active-low; clock i_clk.
- Reset values: all integrators, comb delays, decimation counter, snapshot and o_data are 0; o_valid=0; o_busy=0; FSM=IDLE.
- i_clr=1: same clearing as reset on the next edge, including aborting any comb in progress; no o_valid for an aborted result.
- Arithmetic:
  - All state is two's complement, modulo 2^ACC_WIDTH (wrap, no saturation).
  - i_data is sign-extended to ACC_WIDTH.
- Integrator chain, on each i_sample=1 edge:
  - integ[0] <= integ[0] + ext(i_data).
  - integ[k] <= integ[k] + integ[k-1], using the pre-edge value of integ[k-1] (pipelined).
  - No change when i_sample=0.
- Decimation counter:
  - Counts i_sample pulses 0..DECIM-1 and wraps to 0.
  - Decimation event: the i_sample edge at which the count is DECIM-1.
  - At the event, snap <= pre-edge integ[ORDER-1], FSM -> COMB, stage index k <= 0.
- FSM states IDLE, COMB, OUT:
  - COMB: one comb stage per clock, ORDER cycles total.
    - work <= work - dly[k]; dly[k] <= work; k <= k+1.
    - work starts as snap.
    - After stage ORDER-1, go to OUT.
  - OUT: o_data <= work, o_valid=1 for exactly one cycle, return to IDLE.
  - o_valid rises ORDER+1 edges after the decimation-event edge.
- Integrators keep accepting i_sample every cycle while the FSM is busy.
  - The DECIM >= 8 > ORDER+1 constraint guarantees the FSM is IDLE before the next event.
- o_busy = (FSM != IDLE).
- DC gain is DECIM^ORDER; ORDER=3, DECIM=16 gives gain 4096.
- Input duty: any spacing of i_sample gives identical output values; only timing changes.

Optional Feature:
- Macro: DSM_CIC_WARMUP_EN.
- Defined:
  - A 3-bit warm-up counter suppresses o_valid, and leaves o_data unchanged, for the first ORDER results after reset or i_clr.
  - These results are start-up transients.
  - The counter is cleared by reset and i_clr.
- Not defined: every result is emitted, including transients.

Test Plan:
- Reset/defaults: ORDER=3, DECIM_LOG2=4, IN_WIDTH=2, macro off. Hold reset, then release with i_sample=0 for 100 cycles -> o_data=0, o_valid=0, o_busy=0 throughout.
- DC gain: i_data=+1, i_sample=1 every cycle for 128 samples.
  - o_valid pulses 4 cycles after sample edges 15, 31, 47, ...
  - 4th result onward is exactly 4096.
  - Repeat with i_data=-2 -> -8192 with no wrap error.
- Sparse input: same +1 stimulus with i_sample high every 3rd cycle -> identical result sequence; one o_valid per 16 samples.
- Warm-up: macro on, same DC stimulus -> first o_valid carries 4096; exactly 3 results suppressed; repeat after an i_clr gives the same.
- Clear mid-comb: assert i_clr one cycle after a decimation event while o_busy=1 -> no o_valid for that frame; state zeroed; subsequent zero input gives o_data=0 results.
- Async reset mid-comb: drop i_rst_n asynchronously during COMB -> o_valid and o_busy go to 0 immediately; o_data=0; after release, DC +1 again reaches 4096 at the 4th result.
